// File: rtl/sprite_compositor.sv
// Sprite compositor: merges prioritised sprite layers over a background colour
// into one 4:4:4 RGB stream with a fixed 2-cycle latency, and accumulates
// per-frame overlaps against layer 0 (the player). Each frame's overlaps are
// handed to game logic through a valid/ack handshake with an overrun flag.
module sprite_compositor #(
   parameter int LAYERS     = 4,
   parameter int COLR_BITS  = 4,
   parameter int TRANSP_IDX = 0,
   localparam int LW        = $clog2(LAYERS + 1)
) (
   input  logic                          i_clk_25,
   input  logic                          i_rst_n,
   input  logic                          i_de,
   input  logic                          i_frame,
   input  logic [LAYERS*COLR_BITS-1:0]   i_pix,
   input  logic [LAYERS*12-1:0]          i_colr,
   input  logic [LAYERS-1:0]             i_drawing,
   input  logic [11:0]                   i_bg_colr,
   output logic [3:0]                    o_r,
   output logic [3:0]                    o_g,
   output logic [3:0]                    o_b,
   output logic                          o_de,
   output logic [LW-1:0]                 o_layer,
   output logic [LAYERS-2:0]             o_coll_mask,
   output logic                          o_coll_valid,
   output logic                          o_coll_ovr,
   input  logic                          i_coll_ack
);

   // A single layer has nothing to collide with and would give a zero-width mask.
   if (LAYERS < 2) begin : g_bad_layers
      $error("sprite_compositor: LAYERS must be at least 2");
   end

   localparam logic [COLR_BITS-1:0] TRANSP = COLR_BITS'(TRANSP_IDX);

   logic [LAYERS-1:0]    opaque_d, opaque_q;
   logic [LAYERS*12-1:0] colr_q;
   logic [11:0]          bg_q;
   logic                 de_q;

   logic [11:0]          rgb_d, rgb_q;
   logic [LW-1:0]        layer_d, layer_q;
   logic                 de2_q;

   logic [LAYERS-2:0]    hits, snap;
   logic [LAYERS-2:0]    acc_d, acc_q;
   logic [LAYERS-2:0]    mask_d, mask_q;
   logic                 valid_d, valid_q;
   logic                 ovr_d, ovr_q;

   // A layer is opaque only inside its box and on a non-transparent palette entry.
   always_comb begin
      opaque_d = '0;
      for (int k = 0; k < LAYERS; k++)
         opaque_d[k] = i_drawing[k] && (i_pix[k*COLR_BITS +: COLR_BITS] != TRANSP);
   end

   // Stage 1: register opacity, colours and display enable.
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         opaque_q <= '0;
         colr_q   <= '0;
         bg_q     <= '0;
         de_q     <= 1'b0;
      end else begin
         opaque_q <= opaque_d;
         colr_q   <= i_colr;
         bg_q     <= i_bg_colr;
         de_q     <= i_de;
      end
   end

   // Priority select: lowest-numbered opaque layer wins, background otherwise; blank outside de.
   always_comb begin
      layer_d = LW'(LAYERS);
      rgb_d   = bg_q;
      for (int k = LAYERS - 1; k >= 0; k--) begin
         if (opaque_q[k]) begin
            layer_d = LW'(k);
            rgb_d   = colr_q[k*12 +: 12];
         end
      end
      if (!de_q) begin
         layer_d = LW'(LAYERS);
         rgb_d   = 12'h000;
      end
   end

   // Stage 2: register composited pixel.
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rgb_q   <= '0;
         layer_q <= LW'(LAYERS);
         de2_q   <= 1'b0;
      end else begin
         rgb_q   <= rgb_d;
         layer_q <= layer_d;
         de2_q   <= de_q;
      end
   end

   // Collision accumulate/snapshot; a frame pulse takes precedence over an ack.
   always_comb begin
      hits    = (de_q && opaque_q[0]) ? opaque_q[LAYERS-1:1] : '0;
      snap    = acc_q | hits;
      acc_d   = acc_q | hits;
      mask_d  = mask_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      if (i_frame) begin
         acc_d   = '0;
         mask_d  = snap;
         valid_d = |snap;
         ovr_d   = i_coll_ack ? 1'b0 : (ovr_q | (valid_q & (|snap)));
      end else if (i_coll_ack && valid_q) begin
         valid_d = 1'b0;
         ovr_d   = 1'b0;
      end
   end

   // Collision state registers.
   always_ff @(posedge i_clk_25 or negedge i_rst_n) begin
      if (!i_rst_n) begin
         acc_q   <= '0;
         mask_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         mask_q  <= mask_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
      end
   end

   assign o_r          = rgb_q[11:8];
   assign o_g          = rgb_q[7:4];
   assign o_b          = rgb_q[3:0];
   assign o_de         = de2_q;
   assign o_layer      = layer_q;
   assign o_coll_mask  = mask_q;
   assign o_coll_valid = valid_q;
   assign o_coll_ovr   = ovr_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor (LAYERS=4, COLR_BITS=4, TRANSP_IDX=0).
module tb_sprite_compositor;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        de, frame, ack;
   logic [15:0] pix;
   logic [47:0] colr;
   logic [3:0]  drawing;
   logic [11:0] bg;
   logic [3:0]  r, g, b;
   logic        de_o;
   logic [2:0]  layer;
   logic [2:0]  mask;
   logic        valid, ovr;

   int tests = 0;
   int fails = 0;

   always #20 clk = ~clk;

   sprite_compositor #(.LAYERS(4), .COLR_BITS(4), .TRANSP_IDX(0)) dut (
      .i_clk_25    (clk),
      .i_rst_n     (rst_n),
      .i_de        (de),
      .i_frame     (frame),
      .i_pix       (pix),
      .i_colr      (colr),
      .i_drawing   (drawing),
      .i_bg_colr   (bg),
      .o_r         (r),
      .o_g         (g),
      .o_b         (b),
      .o_de        (de_o),
      .o_layer     (layer),
      .o_coll_mask (mask),
      .o_coll_valid(valid),
      .o_coll_ovr  (ovr),
      .i_coll_ack  (ack)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_pix(input string tag, input logic [11:0] rgb, input logic [2:0] lay, input logic d);
      chk({tag, "_rgb"}, {20'd0, r, g, b}, {20'd0, rgb});
      chk({tag, "_layer"}, {29'd0, layer}, {29'd0, lay});
      chk({tag, "_de"}, {31'd0, de_o}, {31'd0, d});
   endtask

   task automatic chk_coll(input string tag, input logic [2:0] m, input logic v, input logic o);
      chk({tag, "_mask"}, {29'd0, mask}, {29'd0, m});
      chk({tag, "_valid"}, {31'd0, valid}, {31'd0, v});
      chk({tag, "_ovr"}, {31'd0, ovr}, {31'd0, o});
   endtask

   task automatic pulse_frame(input logic with_ack);
      frame = 1'b1;
      ack   = with_ack;
      tick();
      frame = 1'b0;
      ack   = 1'b0;
   endtask

   initial begin
      rst_n   = 1'b0;
      de      = 1'b0;
      frame   = 1'b0;
      ack     = 1'b0;
      pix     = '0;
      colr    = '0;
      drawing = '0;
      bg      = '0;
      repeat (3) tick();
      chk_pix("rst_init", 12'h000, 3'd4, 1'b0);
      chk_coll("rst_init", 3'b000, 1'b0, 1'b0);
      rst_n = 1'b1;
      tick();

      // T2: background with exact 2-cycle latency
      de = 1'b1;
      bg = 12'h35A;
      tick();
      chk_pix("lat_1cyc", 12'h000, 3'd4, 1'b0);
      tick();
      chk_pix("lat_2cyc", 12'h35A, 3'd4, 1'b1);

      // T3: priority between layers 1 and 2
      colr[0*12 +: 12] = 12'hABC;
      colr[1*12 +: 12] = 12'hF00;
      colr[2*12 +: 12] = 12'h0F0;
      colr[3*12 +: 12] = 12'h00F;
      pix[1*4 +: 4] = 4'd5;
      pix[2*4 +: 4] = 4'd7;
      drawing = 4'b0110;
      tick(); tick();
      chk_pix("prio_l1", 12'hF00, 3'd1, 1'b1);
      drawing = 4'b0100;
      tick(); tick();
      chk_pix("prio_l2", 12'h0F0, 3'd2, 1'b1);

      // T4: transparent layer 0 over opaque layer 3
      pix[0*4 +: 4] = 4'd0;
      pix[3*4 +: 4] = 4'd3;
      drawing = 4'b1001;
      tick(); tick();
      chk_pix("transp", 12'h00F, 3'd3, 1'b1);
      pulse_frame(1'b0);
      chk_coll("transp_nocoll", 3'b000, 1'b0, 1'b0);

      // Blanking forces black and background index
      de = 1'b0;
      tick(); tick();
      chk_pix("blank", 12'h000, 3'd4, 1'b0);
      de = 1'b1;

      // T5: one-pixel overlap of layers 0 and 2
      pix[0*4 +: 4] = 4'd1;
      drawing = 4'b0101;
      tick();
      drawing = 4'b0000;
      tick();
      chk_pix("player_win", 12'hABC, 3'd0, 1'b1);
      pulse_frame(1'b0);
      chk_coll("coll_l2", 3'b010, 1'b1, 1'b0);
      pulse_frame(1'b0);
      chk_coll("coll_zero", 3'b000, 1'b0, 1'b0);

      // T6: two overlap frames without ack -> overrun
      pix[1*4 +: 4] = 4'd2;
      drawing = 4'b0011;
      tick();
      drawing = 4'b0000;
      tick();
      pulse_frame(1'b0);
      chk_coll("ovr_f1", 3'b001, 1'b1, 1'b0);
      drawing = 4'b1001;
      pix[0*4 +: 4] = 4'd1;
      tick();
      drawing = 4'b0000;
      tick();
      pulse_frame(1'b0);
      chk_coll("ovr_f2", 3'b100, 1'b1, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk_coll("ack_alone", 3'b100, 1'b0, 1'b0);

      // Overlap present in stage 1 on the frame cycle, frame and ack together
      drawing = 4'b0101;
      tick();
      drawing = 4'b0000;
      pulse_frame(1'b1);
      chk_coll("frame_ack", 3'b010, 1'b1, 1'b0);

      // Overrun then zero snapshot keeps ovr; ack with valid low does nothing
      drawing = 4'b0011;
      tick();
      drawing = 4'b0000;
      pulse_frame(1'b0);
      chk_coll("ovr_again", 3'b001, 1'b1, 1'b1);
      pulse_frame(1'b0);
      chk_coll("zero_keeps_ovr", 3'b000, 1'b0, 1'b1);
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk_coll("ack_idle", 3'b000, 1'b0, 1'b1);

      // T1: mid-stream reset clears pipeline and accumulator asynchronously
      drawing = 4'b0101;
      tick(); tick();
      chk_pix("pre_rst", 12'hABC, 3'd0, 1'b1);
      #5;
      rst_n = 1'b0;
      #1;
      chk_pix("midrst", 12'h000, 3'd4, 1'b0);
      chk_coll("midrst", 3'b000, 1'b0, 1'b0);
      drawing = 4'b0000;
      tick();
      rst_n = 1'b1;
      tick(); tick();
      pulse_frame(1'b0);
      chk_coll("post_rst", 3'b000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
